// File: rtl/seg_display_scan_if.sv
// Bundle between the alarm-clock core and the display scanner: BCD time digits and Alarm in,
// active-low anode, segment and decimal-point drives out.
interface seg_display_scan_if;
    logic       Alarm;
    logic [1:0] Hour_in1;
    logic [3:0] Hour_in0;
    logic [3:0] Min_in1;
    logic [3:0] Min_in0;
    logic [3:0] Sec_in1;
    logic [3:0] Sec_in0;
    logic [5:0] An;
    logic [6:0] Seg;
    logic       Dp;

    // The clock core drives the digits; the display scanner drives the LED pins.
    modport master (
        output Alarm, Hour_in1, Hour_in0, Min_in1, Min_in0, Sec_in1, Sec_in0,
        input  An, Seg, Dp
    );

    modport slave (
        input  Alarm, Hour_in1, Hour_in0, Min_in1, Min_in0, Sec_in1, Sec_in0,
        output An, Seg, Dp
    );
endinterface

// File: rtl/seg_display_scan.sv
// Time-multiplexes HH:MM:SS onto a common-anode 6-digit 7-segment display with registered outputs.
// Define DISP_BLINK_EN to blink the whole display while Alarm is high; otherwise Alarm lights the seconds-units dot.
module seg_display_scan #(
    parameter int SCAN_DIV  = 4,
    parameter int BLINK_DIV = 8
) (
    input  logic              CLK,
    input  logic              reset,
    seg_display_scan_if.slave bus
);

    generate
        if (SCAN_DIV < 1 || SCAN_DIV > 65535) begin : g_badScanDiv
            $error("SCAN_DIV must be in 1..65535");
        end
        if (BLINK_DIV < 1 || BLINK_DIV > 255) begin : g_badBlinkDiv
            $error("BLINK_DIV must be in 1..255");
        end
    endgenerate

    logic [15:0] r_divCnt;
    logic [2:0]  r_idx;
    logic [5:0]  r_an;
    logic [6:0]  r_seg;
    logic        r_dp;

    logic [3:0]  w_digit;
    logic        w_valid;
    logic [5:0]  w_an;
    logic [6:0]  w_seg;
    logic        w_dpLit;
    logic        w_blank;
    logic        w_slotEnd;

    function automatic logic [6:0] decodeDigit(input logic [3:0] value, input logic valid);
        logic [6:0] segs;
        case (value)
            4'd0:    segs = 7'b1000000;
            4'd1:    segs = 7'b1111001;
            4'd2:    segs = 7'b0100100;
            4'd3:    segs = 7'b0110000;
            4'd4:    segs = 7'b0011001;
            4'd5:    segs = 7'b0010010;
            4'd6:    segs = 7'b0000010;
            4'd7:    segs = 7'b1111000;
            4'd8:    segs = 7'b0000000;
            4'd9:    segs = 7'b0010000;
            default: segs = 7'b0111111;
        endcase
        if (!valid) segs = 7'b0111111;
        return segs;
    endfunction

    assign w_slotEnd = (r_divCnt == 16'(SCAN_DIV - 1));

    // Tens digits have tighter legal ranges than units; anything out of range shows a dash.
    always_comb begin
        w_digit = 4'd0;
        w_valid = 1'b0;
        w_an    = 6'b111111;
        case (r_idx)
            3'd0: begin w_digit = bus.Sec_in0;             w_valid = (bus.Sec_in0 <= 4'd9);  w_an = 6'b111110; end
            3'd1: begin w_digit = bus.Sec_in1;             w_valid = (bus.Sec_in1 <= 4'd5);  w_an = 6'b111101; end
            3'd2: begin w_digit = bus.Min_in0;             w_valid = (bus.Min_in0 <= 4'd9);  w_an = 6'b111011; end
            3'd3: begin w_digit = bus.Min_in1;             w_valid = (bus.Min_in1 <= 4'd5);  w_an = 6'b110111; end
            3'd4: begin w_digit = bus.Hour_in0;            w_valid = (bus.Hour_in0 <= 4'd9); w_an = 6'b101111; end
            3'd5: begin w_digit = {2'b00, bus.Hour_in1};   w_valid = (bus.Hour_in1 != 2'd3); w_an = 6'b011111; end
            default: begin w_digit = 4'd0; w_valid = 1'b0; w_an = 6'b111111; end
        endcase
        w_seg = decodeDigit(w_digit, w_valid);
    end

`ifdef DISP_BLINK_EN
    logic [7:0] r_frameCnt;
    logic       r_blinkPhase;
    logic       w_frameEnd;

    assign w_frameEnd = w_slotEnd && (r_idx == 3'd5);
    assign w_dpLit    = (r_idx == 3'd2) || (r_idx == 3'd4);
    assign w_blank    = bus.Alarm && !r_blinkPhase;

    // Dropping Alarm parks the blinker in its visible phase so the next alarm starts lit.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_frameCnt   <= 8'd0;
            r_blinkPhase <= 1'b1;
        end else if (!bus.Alarm) begin
            r_frameCnt   <= 8'd0;
            r_blinkPhase <= 1'b1;
        end else if (w_frameEnd) begin
            if (r_frameCnt == 8'(BLINK_DIV - 1)) begin
                r_frameCnt   <= 8'd0;
                r_blinkPhase <= ~r_blinkPhase;
            end else begin
                r_frameCnt <= r_frameCnt + 8'd1;
            end
        end
    end
`else
    assign w_dpLit = (r_idx == 3'd2) || (r_idx == 3'd4) || (bus.Alarm && (r_idx == 3'd0));
    assign w_blank = 1'b0;
`endif

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_divCnt <= 16'd0;
            r_idx    <= 3'd0;
            r_an     <= 6'b111111;
            r_seg    <= 7'b1111111;
            r_dp     <= 1'b1;
        end else begin
            r_an  <= w_blank ? 6'b111111  : w_an;
            r_seg <= w_blank ? 7'b1111111 : w_seg;
            r_dp  <= w_blank ? 1'b1       : !w_dpLit;
            if (w_slotEnd) begin
                r_divCnt <= 16'd0;
                r_idx    <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
            end else begin
                r_divCnt <= r_divCnt + 16'd1;
            end
        end
    end

    assign bus.An  = r_an;
    assign bus.Seg = r_seg;
    assign bus.Dp  = r_dp;

endmodule

// File: tb/tb_seg_display_scan.sv
// Directed bench for seg_display_scan: a SCAN_DIV=4 instance for scan/decode/reset and a
// SCAN_DIV=1, BLINK_DIV=2 instance for Alarm behaviour in whichever build is compiled.
module tb_seg_display_scan;

    logic clk;
    logic resetA;
    logic resetB;
    int   checks;
    int   errors;

    seg_display_scan_if busA ();
    seg_display_scan_if busB ();

    seg_display_scan #(.SCAN_DIV(4), .BLINK_DIV(8)) dutA (
        .CLK   (clk),
        .reset (resetA),
        .bus   (busA)
    );

    seg_display_scan #(.SCAN_DIV(1), .BLINK_DIV(2)) dutB (
        .CLK   (clk),
        .reset (resetB),
        .bus   (busB)
    );

    // Free-running clock; DUT samples on posedge, the bench observes on negedge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S6 = 7'b0000010, S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000, S9 = 7'b0010000, SDASH = 7'b0111111, SOFF = 7'b1111111;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input bit useB,
                               input logic [5:0] expAn, input logic [6:0] expSeg, input logic expDp);
        logic [13:0] observed;
        logic [13:0] expected;
        observed = useB ? {busB.An, busB.Seg, busB.Dp} : {busA.An, busA.Seg, busA.Dp};
        expected = {expAn, expSeg, expDp};
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed An=%b Seg=%b Dp=%b, expected An=%b Seg=%b Dp=%b",
                   tag, observed[13:8], observed[7:1], observed[0], expAn, expSeg, expDp);
        end
    endtask

    task automatic applyStimulus(input bit useB, input logic [1:0] h1, input logic [3:0] h0,
                                 input logic [3:0] m1, input logic [3:0] m0,
                                 input logic [3:0] s1, input logic [3:0] s0);
        if (useB) begin
            busB.Hour_in1 = h1; busB.Hour_in0 = h0; busB.Min_in1 = m1;
            busB.Min_in0  = m0; busB.Sec_in1  = s1; busB.Sec_in0 = s0;
        end else begin
            busA.Hour_in1 = h1; busA.Hour_in0 = h0; busA.Min_in1 = m1;
            busA.Min_in0  = m0; busA.Sec_in1  = s1; busA.Sec_in0 = s0;
        end
    endtask

    // Edge numbers in comments count posedges after reset release; slot n shows at edges 4n+1..4n+4.
    initial begin
        checks = 0;
        errors = 0;
        resetA = 1'b1;
        resetB = 1'b1;
        busA.Alarm = 1'b0;
        busB.Alarm = 1'b0;
        applyStimulus(1'b0, 2'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        applyStimulus(1'b1, 2'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);

        step(2);
        checkOutput("resetBlank", 1'b0, 6'b111111, SOFF, 1'b1);
        resetA = 1'b0;

        step(1);  // edge 1
        checkOutput("firstEdge_idx0", 1'b0, 6'b111110, S6, 1'b1);
        step(3);  // edge 4
        checkOutput("idx0_held", 1'b0, 6'b111110, S6, 1'b1);
        step(1);  // edge 5
        checkOutput("idx1_sec1", 1'b0, 6'b111101, S5, 1'b1);
        step(4);  // edge 9
        checkOutput("idx2_min0_dp", 1'b0, 6'b111011, S4, 1'b0);
        step(4);  // edge 13
        checkOutput("idx3_min1", 1'b0, 6'b110111, S3, 1'b1);
        step(4);  // edge 17
        checkOutput("idx4_hour0_dp", 1'b0, 6'b101111, S2, 1'b0);
        step(4);  // edge 21
        checkOutput("idx5_hour1", 1'b0, 6'b011111, S1, 1'b1);
        step(4);  // edge 25
        checkOutput("frameWrap", 1'b0, 6'b111110, S6, 1'b1);

        busA.Sec_in0 = 4'd3;
        step(1);  // edge 26
        checkOutput("midSlot_sec0_3", 1'b0, 6'b111110, S3, 1'b1);
        busA.Sec_in0 = 4'd4;
        step(1);  // edge 27
        checkOutput("midSlot_sec0_4", 1'b0, 6'b111110, S4, 1'b1);

        busA.Min_in0  = 4'hA;
        busA.Hour_in1 = 2'd3;
        step(6);  // edge 33
        checkOutput("invalid_min0_A", 1'b0, 6'b111011, SDASH, 1'b0);
        busA.Min_in1 = 4'd6;
        step(4);  // edge 37
        checkOutput("invalid_min1_6", 1'b0, 6'b110111, SDASH, 1'b1);
        step(4);  // edge 41
        checkOutput("valid_hour0", 1'b0, 6'b101111, S2, 1'b0);
        step(4);  // edge 45
        checkOutput("invalid_hour1_3", 1'b0, 6'b011111, SDASH, 1'b1);

        applyStimulus(1'b0, 2'd2, 4'd9, 4'd5, 4'd8, 4'd0, 4'd7);
        step(4);  // edge 49
        checkOutput("dec7", 1'b0, 6'b111110, S7, 1'b1);
        step(4);  // edge 53
        checkOutput("dec0", 1'b0, 6'b111101, S0, 1'b1);
        step(4);  // edge 57
        checkOutput("dec8", 1'b0, 6'b111011, S8, 1'b0);
        step(4);  // edge 61
        checkOutput("dec5_min1max", 1'b0, 6'b110111, S5, 1'b1);
        step(4);  // edge 65
        checkOutput("dec9", 1'b0, 6'b101111, S9, 1'b0);
        step(4);  // edge 69
        checkOutput("dec2_hour1max", 1'b0, 6'b011111, S2, 1'b1);

        step(17); // edge 86, mid idx3 of the next frame
        checkOutput("preReset_idx3", 1'b0, 6'b110111, S5, 1'b1);
        #2 resetA = 1'b1;
        #1 checkOutput("asyncResetBlank", 1'b0, 6'b111111, SOFF, 1'b1);
        step(3);
        checkOutput("heldInReset", 1'b0, 6'b111111, SOFF, 1'b1);
        resetA = 1'b0;
        step(1);
        checkOutput("restart_idx0", 1'b0, 6'b111110, S7, 1'b1);
        step(4);
        checkOutput("restart_idx1", 1'b0, 6'b111101, S0, 1'b1);

        // Second instance: SCAN_DIV=1 so edge k shows idx (k-1)%6.
        busB.Alarm = 1'b1;
        resetB = 1'b0;
`ifdef DISP_BLINK_EN
        step(1);  // edge 1
        checkOutput("blink_visible_start", 1'b1, 6'b111110, S6, 1'b1);
        step(11); // edge 12
        checkOutput("blink_visible_end", 1'b1, 6'b011111, S1, 1'b1);
        step(1);  // edge 13
        checkOutput("blink_blank_start", 1'b1, 6'b111111, SOFF, 1'b1);
        step(11); // edge 24
        checkOutput("blink_blank_end", 1'b1, 6'b111111, SOFF, 1'b1);
        step(1);  // edge 25
        checkOutput("blink_visible_again", 1'b1, 6'b111110, S6, 1'b1);
        step(13); // edge 38, inside second blank half-period
        checkOutput("blink_blank_second", 1'b1, 6'b111111, SOFF, 1'b1);
        busB.Alarm = 1'b0;
        step(1);  // edge 39
        checkOutput("alarmOff_resume", 1'b1, 6'b111011, S4, 1'b0);
        step(6);  // edge 45
        checkOutput("alarmOff_noBlank", 1'b1, 6'b111011, S4, 1'b0);
`else
        step(1);  // edge 1
        checkOutput("alarmDot_idx0", 1'b1, 6'b111110, S6, 1'b0);
        step(1);  // edge 2
        checkOutput("scanDiv1_idx1", 1'b1, 6'b111101, S5, 1'b1);
        step(1);  // edge 3
        checkOutput("scanDiv1_idx2", 1'b1, 6'b111011, S4, 1'b0);
        step(10); // edge 13
        checkOutput("alarmDot_noBlank", 1'b1, 6'b111110, S6, 1'b0);
        busB.Alarm = 1'b0;
        step(6);  // edge 19
        checkOutput("alarmOff_dotDark", 1'b1, 6'b111110, S6, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
